dtree_sample_sequencer: RTL and testbench

Hardware-side driver and collector for the combinational printed decision-tree classifier.
- Accepts 8-bit feature samples over a valid/ready stream and buffers them in a small FIFO.
- Applies one sample at a time to the classifier's X16 input and waits a programmable settle time.
- Captures the 4-bit class output and returns it, paired with its feature, on a valid/ready result stream.
- Replaces the file-driven stimulus/capture loop for on-chip and emulation runs.

---
 rtl/dtree_sample_sequencer.sv | 154 +++++++++++++++
 tb/tb_dtree_sample_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtree_sample_sequencer.sv
// dtree_sample_sequencer: drives the combinational decision-tree classifier
// from a buffered sample stream and returns (class, feature) result pairs.
// Optional build macro: DTREE_SEQ_CLASS_HIST_EN adds a per-class result histogram
// (ports hist_sel / hist_count).
module dtree_sample_sequencer #(
  parameter int unsigned FEAT_W  = 8,
  parameter int unsigned CLASS_W = 4,
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [FEAT_W-1:0]  in_data,
  output logic               in_ready,
  output logic [FEAT_W-1:0]  feat_out,
  input  logic [CLASS_W-1:0] class_in,
  output logic               res_valid,
  output logic [CLASS_W-1:0] res_class,
  output logic [FEAT_W-1:0]  res_feat,
  input  logic               res_ready,
  output logic               busy,
  output logic [15:0]        sample_cnt
`ifdef DTREE_SEQ_CLASS_HIST_EN
  ,
  input  logic [CLASS_W-1:0] hist_sel,
  output logic [15:0]        hist_count
`endif
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, APPLY, HOLD} state_t;

  state_t            state, state_nxt;
  logic [FEAT_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, wr_nxt, rd_nxt, occ_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              empty, push;
  logic              pop, dec, capture, done;

  assign empty = (wr_ptr == rd_ptr);
  assign push  = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = APPLY;
      APPLY:   if (cnt == '0) state_nxt = HOLD;
      HOLD:    if (res_ready) state_nxt = empty ? IDLE : APPLY;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM control strobes
  always_comb begin
    pop     = 1'b0;
    dec     = 1'b0;
    capture = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE:  pop = !empty;
      APPLY: begin
        dec     = (cnt != '0);
        capture = (cnt == '0);
      end
      HOLD: begin
        done = res_ready;
        pop  = res_ready && !empty;
      end
      default: ;
    endcase
  end

  // Next pointer values feed the registered in_ready / busy flags
  always_comb begin
    wr_nxt  = wr_ptr + PW'(push);
    rd_nxt  = rd_ptr + PW'(pop);
    occ_nxt = wr_nxt - rd_nxt;
  end

  // FIFO storage; no reset needed, validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  // FIFO pointers and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      in_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      wr_ptr   <= wr_nxt;
      rd_ptr   <= rd_nxt;
      in_ready <= (occ_nxt != PW'(DEPTH));
      busy     <= (occ_nxt != '0) || (state_nxt != IDLE);
    end
  end

  // Classifier drive, settle counter, result capture and handshake count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      feat_out   <= '0;
      cnt        <= '0;
      res_valid  <= 1'b0;
      res_class  <= '0;
      res_feat   <= '0;
      sample_cnt <= '0;
    end else begin
      if (pop) begin
        feat_out <= mem[rd_ptr[AW-1:0]];
        cnt      <= CNT_W'(SETTLE - 1);
      end else if (dec) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (capture) begin
        res_valid <= 1'b1;
        res_class <= class_in;
        res_feat  <= feat_out;
      end else if (done) begin
        res_valid  <= 1'b0;
        sample_cnt <= sample_cnt + 16'd1;
      end
    end
  end

`ifdef DTREE_SEQ_CLASS_HIST_EN
  localparam int unsigned NCLS = 2 ** CLASS_W;
  logic [15:0] hist [NCLS];

  // Saturating per-class result counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCLS; i++) hist[i] <= '0;
    end else if (done && (hist[res_class] != 16'hFFFF)) begin
      hist[res_class] <= hist[res_class] + 16'd1;
    end
  end

  assign hist_count = hist[hist_sel];
`endif

endmodule

// File: tb/tb_dtree_sample_sequencer.sv
// Randomized + directed bench for dtree_sample_sequencer (SETTLE=2, DEPTH=4).
// A scoreboard queue of accepted features predicts result order and content.
module tb_dtree_sample_sequencer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SETTLE = 2;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [7:0]  in_data, feat_out, res_feat;
  logic [3:0]  class_in, res_class;
  logic        res_valid, res_ready, busy;
  logic [15:0] sample_cnt;
`ifdef DTREE_SEQ_CLASS_HIST_EN
  logic [3:0]  hist_sel;
  logic [15:0] hist_count;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0]  exp_q[$];
  logic [15:0] exp_cnt;
  logic        mon_en, rr_rand;
  logic        hold_prev;
  logic [3:0]  hold_cls;
  logic [7:0]  hold_feat;

  dtree_sample_sequencer #(.FEAT_W(8), .CLASS_W(4), .SETTLE(SETTLE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .feat_out(feat_out), .class_in(class_in),
    .res_valid(res_valid), .res_class(res_class), .res_feat(res_feat), .res_ready(res_ready),
    .busy(busy), .sample_cnt(sample_cnt)
`ifdef DTREE_SEQ_CLASS_HIST_EN
    , .hist_sel(hist_sel), .hist_count(hist_count)
`endif
  );

  // Stand-in classifier: a fixed combinational function of the feature
  function automatic logic [3:0] cls_fn(input logic [7:0] f);
    return f[3:0] ^ f[7:4] ^ 4'h8;
  endfunction

  assign class_in = cls_fn(feat_out);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Random result backpressure
  always @(negedge clk) if (rr_rand) res_ready = 1'($urandom_range(0, 1));

  // Scoreboard monitor: ordering, content, hold stability, handshake count
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      check("sample_cnt", 32'(sample_cnt), 32'(exp_cnt));
      if (hold_prev) begin
        check("hold_valid", 32'(res_valid), 32'd1);
        check("hold_class", 32'(res_class), 32'(hold_cls));
        check("hold_feat",  32'(res_feat),  32'(hold_feat));
      end
      hold_prev = res_valid && !res_ready;
      hold_cls  = res_class;
      hold_feat = res_feat;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("result_expected", 32'(exp_q.size() != 0), 32'd1);
        end else begin
          logic [7:0] f;
          f = exp_q.pop_front();
          check("res_feat",  32'(res_feat),  32'(f));
          check("res_class", 32'(res_class), 32'(cls_fn(f)));
          exp_cnt = exp_cnt + 16'd1;
        end
      end
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic push(input logic [7:0] f, input int max_wait);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = f;
    while (!in_ready && n < max_wait) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", 32'(in_ready), 32'd1);
    if (in_ready) exp_q.push_back(f);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #3;
      if (exp_q.size() == 0 && !busy && !res_valid) break;
    end
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_res_valid(input string tag);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    check(tag, 32'(res_valid), 32'd1);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_cnt = '0;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  initial begin
    int t_res[$];
    int k;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; res_ready = 1'b1;
    rr_rand = 1'b0; mon_en = 1'b0; exp_cnt = '0; hold_prev = 1'b0;
`ifdef DTREE_SEQ_CLASS_HIST_EN
    hist_sel = '0;
`endif
    do_reset();

    // Reset state
    check("rst_in_ready",  32'(in_ready),   32'd1);
    check("rst_feat_out",  32'(feat_out),   32'd0);
    check("rst_res_valid", 32'(res_valid),  32'd0);
    check("rst_res_class", 32'(res_class),  32'd0);
    check("rst_res_feat",  32'(res_feat),   32'd0);
    check("rst_busy",      32'(busy),       32'd0);
    check("rst_cnt",       32'(sample_cnt), 32'd0);

    // Latency: push 0x5A at E0, result after E0+SETTLE+1
    in_valid = 1'b1; in_data = 8'h5A; exp_q.push_back(8'h5A);
    @(negedge clk); in_valid = 1'b0;                       // after E0
    check("lat_e0_feat", 32'(feat_out), 32'd0);
    check("lat_e0_busy", 32'(busy), 32'd1);
    @(negedge clk);                                         // after E1
    check("lat_e1_feat",  32'(feat_out),  32'h5A);
    check("lat_e1_valid", 32'(res_valid), 32'd0);
    @(negedge clk);                                         // after E2
    check("lat_e2_valid", 32'(res_valid), 32'd0);
    @(negedge clk);                                         // after E3
    check("lat_e3_valid", 32'(res_valid), 32'd1);
    check("lat_e3_class", 32'(res_class), 32'd7);
    check("lat_e3_feat",  32'(res_feat),  32'h5A);
    @(negedge clk);                                         // after E4
    check("lat_e4_cnt",   32'(sample_cnt), 32'd1);
    check("lat_e4_valid", 32'(res_valid),  32'd0);
    drain("lat");

    // Burst of 4 with continuous res_ready: results SETTLE+1 cycles apart
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (res_valid) t_res.push_back(cyc);
      if (i < 4) begin
        check("burst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = 8'(i + 1); exp_q.push_back(8'(i + 1));
      end else begin
        in_valid = 1'b0;
      end
    end
    check("burst_results", 32'(t_res.size()), 32'd4);
    for (int i = 1; i < t_res.size(); i++)
      check("burst_spacing", 32'(t_res[i] - t_res[i-1]), 32'(SETTLE + 1));
    drain("burst");
    check("burst_cnt", 32'(sample_cnt), 32'd5);

    // Backpressure: one result held, then offer 6 over 10 cycles
    res_ready = 1'b0;
    push(8'h80, 10);
    wait_res_valid("bp_first_valid");
    k = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (k < 6) begin
        in_valid = 1'b1; in_data = 8'(8'h81 + k);
        if (in_ready) begin
          exp_q.push_back(8'(8'h81 + k));
          k++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk); in_valid = 1'b0;
    check("bp_accepted", 32'(k), 32'(DEPTH));
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_held_feat", 32'(res_feat), 32'h80);
    res_ready = 1'b1;
    drain("bp");

    // Async reset while holding a result with 2 buffered samples
    res_ready = 1'b0;
    push(8'hC1, 10); push(8'hC2, 10); push(8'hC3, 10);
    wait_res_valid("ar_hold_valid");
    @(negedge clk);
    check("ar_pre_busy", 32'(busy), 32'd1);
    mon_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("ar_res_valid", 32'(res_valid),  32'd0);
    check("ar_in_ready",  32'(in_ready),   32'd1);
    check("ar_busy",      32'(busy),       32'd0);
    check("ar_cnt",       32'(sample_cnt), 32'd0);
    check("ar_feat_out",  32'(feat_out),   32'd0);
    exp_q.delete();
    exp_cnt = '0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); mon_en = 1'b1;
    res_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("ar_no_stale", 32'(sample_cnt), 32'd0);

`ifdef DTREE_SEQ_CLASS_HIST_EN
    // Histogram: 3 of class 2, 1 of class 9
    do_reset();
    push(8'h0A, 10); push(8'h0A, 10); push(8'h01, 10); push(8'h0A, 10);
    drain("hist");
    hist_sel = 4'd2; #1 check("hist_2", 32'(hist_count), 32'd3);
    hist_sel = 4'd9; #1 check("hist_9", 32'(hist_count), 32'd1);
    hist_sel = 4'd0; #1 check("hist_0", 32'(hist_count), 32'd0);
`endif

    // Randomized traffic with random backpressure
    rr_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      push(8'($urandom), 60);
    end
    @(negedge clk);
    rr_rand = 1'b0;
    res_ready = 1'b1;
    drain("rand");

    // Counter wrap from 0xFFFF
    @(negedge clk);
    #3;
    force dut.sample_cnt = 16'hFFFF;
    exp_cnt = 16'hFFFF;
    #1 release dut.sample_cnt;
    @(negedge clk);
    #3 check("wrap_pre", 32'(sample_cnt), 32'hFFFF);
    push(8'h33, 10);
    drain("wrap");
    check("wrap_cnt", 32'(sample_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
